// File: rtl/upsample_ctrl.sv
// Upsample sequencer: walks the 2x2 input windows of an NxN map in raster order, issues
// interpolator reads, and LAT cycles later drives the matching write to the output bank.
module upsample_ctrl #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  size_upsample,
    output logic        busy,
    output logic        done,
    output logic        in_rd_en,
    output logic [11:0] in_addr,
    output logic        en_write_out,
    output logic [3:0]  write_mode,
    output logic [13:0] addr_output
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

    // Index of the last window row/column: N-2 with N = 4<<sz.
    function automatic logic [5:0] last_idx(input logic [2:0] sz);
        logic [6:0] n;
        logic [6:0] m;
        n = 7'd4 << sz;
        m = n - 7'd2;
        return m[5:0];
    endfunction

    function automatic logic [11:0] in_index(input logic [2:0] sz, input logic [5:0] i,
                                             input logic [5:0] j);
        logic [11:0] row;
        row = {6'd0, i} << (sz + 3'd2);
        return row + {6'd0, j};
    endfunction

    // Centre of the 2x2 output block: (2i+1)*W + (2j+1), W = 8<<sz.
    function automatic logic [13:0] out_index(input logic [2:0] sz, input logic [5:0] i,
                                              input logic [5:0] j);
        logic [13:0] row;
        row = {7'd0, i, 1'b1} << (sz + 3'd3);
        return row + {7'd0, j, 1'b1};
    endfunction

    function automatic logic [3:0] win_mode(input logic [2:0] sz, input logic [5:0] i,
                                            input logic [5:0] j);
        logic [5:0] last;
        logic [3:0] r;
        logic [3:0] c;
        last = last_idx(sz);
        r = (i == 6'd0) ? 4'd0 : ((i == last) ? 4'd2 : 4'd1);
        c = (j == 6'd0) ? 4'd0 : ((j == last) ? 4'd2 : 4'd1);
        return r * 4'd3 + c;
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  size_q, size_d;
    logic [5:0]  i_q, i_d;
    logic [5:0]  j_q, j_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [11:0] in_addr_q, in_addr_d;
    logic        rd_go;
    logic [5:0]  last_q;
    logic        drain_busy;

    // Stage 0 is the read issue; stage LAT is the write presented to the output bank.
    logic [LAT:0]        vld_pipe_q, vld_pipe_d;
    logic [LAT:0][3:0]   mode_pipe_q, mode_pipe_d;
    logic [LAT:0][13:0]  oaddr_pipe_q, oaddr_pipe_d;

    assign last_q     = last_idx(size_q);
    assign drain_busy = |vld_pipe_q[LAT-1:0];

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        i_d     = i_q;
        j_d     = j_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_go   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && size_upsample <= 3'd4) begin
                    state_d = S_RUN;
                    size_d  = size_upsample;
                    i_d     = 6'd0;
                    j_d     = 6'd0;
                    rd_go   = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                if (i_q == last_q && j_q == last_q) begin
                    state_d = S_DRAIN;
                end else begin
                    rd_go = 1'b1;
                    if (j_q == last_q) begin
                        j_d = 6'd0;
                        i_d = i_q + 6'd1;
                    end else begin
                        j_d = j_q + 6'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Once only the final stage may hold a write, done lands right after it.
                if (!drain_busy) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_addr_d    = rd_go ? in_index(size_d, i_d, j_d) : 12'd0;
        vld_pipe_d   = {vld_pipe_q[LAT-1:0], rd_go};
        mode_pipe_d  = {mode_pipe_q[LAT-1:0], (rd_go ? win_mode(size_d, i_d, j_d) : 4'd0)};
        oaddr_pipe_d = {oaddr_pipe_q[LAT-1:0], (rd_go ? out_index(size_d, i_d, j_d) : 14'd0)};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            size_q       <= 3'd0;
            i_q          <= 6'd0;
            j_q          <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            in_addr_q    <= 12'd0;
            vld_pipe_q   <= '0;
            mode_pipe_q  <= '0;
            oaddr_pipe_q <= '0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            i_q          <= i_d;
            j_q          <= j_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            in_addr_q    <= in_addr_d;
            vld_pipe_q   <= vld_pipe_d;
            mode_pipe_q  <= mode_pipe_d;
            oaddr_pipe_q <= oaddr_pipe_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign in_rd_en     = vld_pipe_q[0];
    assign in_addr      = in_addr_q;
    assign en_write_out = vld_pipe_q[LAT];
    assign write_mode   = mode_pipe_q[LAT];
    assign addr_output  = oaddr_pipe_q[LAT];

endmodule

// File: tb/tb_upsample_ctrl.sv
// Directed bench for upsample_ctrl (LAT=2): cycle-exact 4x4 run, larger sizes, ignored
// starts, back-to-back restart, illegal size and mid-run reset.
module tb_upsample_ctrl;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  size_upsample = 3'd0;
    logic        busy, done, in_rd_en, en_write_out;
    logic [11:0] in_addr;
    logic [3:0]  write_mode;
    logic [13:0] addr_output;

    int checks = 0;
    int errors = 0;

    int r_rd, r_wr, r_first_mode, r_first_addr, r_first_cyc;
    int r_last_mode, r_last_addr, r_last_cyc, r_last_in_addr;
    int r_done_cyc, r_done_last, r_done_cnt, r_gap, r_idle_nz, r_busy_cnt;

    always #5 clk = ~clk;

    upsample_ctrl #(.LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .size_upsample(size_upsample),
        .busy(busy), .done(done), .in_rd_en(in_rd_en), .in_addr(in_addr),
        .en_write_out(en_write_out), .write_mode(write_mode), .addr_output(addr_output)
    );

    // Start a run at cycle 0 and record activity for cycles 1..limit. Extra start pulses at
    // cycles p0/p1/p2; size input is wiggled to 2 during cycles 2..8.
    task automatic run(input logic [2:0] sz, input int p0, input int p1, input int p2,
                       input int limit);
        bit prev_en;
        r_rd = 0; r_wr = 0; r_first_mode = -1; r_first_addr = -1; r_first_cyc = -1;
        r_last_mode = -1; r_last_addr = -1; r_last_cyc = -1; r_last_in_addr = -1;
        r_done_cyc = -1; r_done_last = -1; r_done_cnt = 0; r_gap = 0; r_idle_nz = 0;
        r_busy_cnt = 0; prev_en = 1'b0;
        @(negedge clk);
        size_upsample = sz;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = (c == p0) || (c == p1) || (c == p2);
            size_upsample = (c >= 2 && c <= 8) ? 3'd2 : sz;
            if (in_rd_en) begin
                r_rd++;
                r_last_in_addr = in_addr;
            end
            if (en_write_out) begin
                r_wr++;
                if (r_wr == 1) begin
                    r_first_mode = write_mode; r_first_addr = addr_output; r_first_cyc = c;
                end else if (!prev_en) begin
                    r_gap++;
                end
                r_last_mode = write_mode; r_last_addr = addr_output; r_last_cyc = c;
            end else if (write_mode != 4'd0 || addr_output != 14'd0) begin
                r_idle_nz++;
            end
            prev_en = en_write_out;
            if (done) begin
                r_done_cnt++;
                if (r_done_cyc < 0) r_done_cyc = c;
                r_done_last = c;
            end
            if (busy) r_busy_cnt++;
        end
        start = 1'b0;
        size_upsample = sz;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        size_upsample = 3'd0;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got=%b exp=0", in_rd_en); end
        checks++; if (in_addr !== 12'd0) begin errors++; $display("FAIL reset_in_addr got=%0d exp=0", in_addr); end
        checks++; if (en_write_out !== 1'b0) begin errors++; $display("FAIL reset_en_write got=%b exp=0", en_write_out); end
        checks++; if (write_mode !== 4'd0) begin errors++; $display("FAIL reset_mode got=%0d exp=0", write_mode); end
        checks++; if (addr_output !== 14'd0) begin errors++; $display("FAIL reset_addr_out got=%0d exp=0", addr_output); end
        start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int in_tab[9]  = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int out_tab[9] = '{9, 11, 13, 25, 27, 29, 41, 43, 45};
        bit exp_rd, exp_wr;
        int exp_mode, exp_addr;
        @(negedge clk);
        size_upsample = 3'd0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp_rd = (c >= 1 && c <= 9);
            exp_wr = (c >= 3 && c <= 11);
            exp_mode = exp_wr ? c - 3 : 0;
            exp_addr = exp_wr ? out_tab[c - 3] : 0;
            checks++; if (in_rd_en !== exp_rd) begin errors++; $display("FAIL basic_rd_en c=%0d got=%b exp=%b", c, in_rd_en, exp_rd); end
            if (exp_rd) begin
                checks++; if (in_addr !== 12'(in_tab[c - 1])) begin errors++; $display("FAIL basic_in_addr c=%0d got=%0d exp=%0d", c, in_addr, in_tab[c - 1]); end
            end
            checks++; if (en_write_out !== exp_wr) begin errors++; $display("FAIL basic_en_write c=%0d got=%b exp=%b", c, en_write_out, exp_wr); end
            checks++; if (write_mode !== 4'(exp_mode)) begin errors++; $display("FAIL basic_mode c=%0d got=%0d exp=%0d", c, write_mode, exp_mode); end
            checks++; if (addr_output !== 14'(exp_addr)) begin errors++; $display("FAIL basic_addr_out c=%0d got=%0d exp=%0d", c, addr_output, exp_addr); end
            checks++; if (done !== (c == 12)) begin errors++; $display("FAIL basic_done c=%0d got=%b exp=%b", c, done, (c == 12)); end
            checks++; if (busy !== (c <= 12)) begin errors++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy, (c <= 12)); end
        end
    endtask

    task automatic test_size1();
        run(3'd1, 0, 0, 0, 60);
        checks++; if (r_wr != 49) begin errors++; $display("FAIL s1_wr_count got=%0d exp=49", r_wr); end
        checks++; if (r_rd != 49) begin errors++; $display("FAIL s1_rd_count got=%0d exp=49", r_rd); end
        checks++; if (r_first_mode != 0 || r_first_addr != 17) begin errors++; $display("FAIL s1_first got=mode%0d/addr%0d exp=mode0/addr17", r_first_mode, r_first_addr); end
        checks++; if (r_first_cyc != 3) begin errors++; $display("FAIL s1_first_cyc got=%0d exp=3", r_first_cyc); end
        checks++; if (r_last_mode != 8 || r_last_addr != 221) begin errors++; $display("FAIL s1_last got=mode%0d/addr%0d exp=mode8/addr221", r_last_mode, r_last_addr); end
        checks++; if (r_last_in_addr != 54) begin errors++; $display("FAIL s1_last_in_addr got=%0d exp=54", r_last_in_addr); end
        checks++; if (r_done_cyc != 52 || r_done_cnt != 1) begin errors++; $display("FAIL s1_done got=cyc%0d/cnt%0d exp=cyc52/cnt1", r_done_cyc, r_done_cnt); end
        checks++; if (r_gap != 0) begin errors++; $display("FAIL s1_gaps got=%0d exp=0", r_gap); end
        checks++; if (r_idle_nz != 0) begin errors++; $display("FAIL s1_idle_nonzero got=%0d exp=0", r_idle_nz); end
        checks++; if (r_busy_cnt != 52) begin errors++; $display("FAIL s1_busy_cycles got=%0d exp=52", r_busy_cnt); end
    endtask

    task automatic test_start_ignored();
        run(3'd1, 5, 50, 52, 60);
        checks++; if (r_wr != 49) begin errors++; $display("FAIL ign_wr_count got=%0d exp=49", r_wr); end
        checks++; if (r_rd != 49) begin errors++; $display("FAIL ign_rd_count got=%0d exp=49", r_rd); end
        checks++; if (r_done_cnt != 1 || r_done_cyc != 52) begin errors++; $display("FAIL ign_done got=cnt%0d/cyc%0d exp=cnt1/cyc52", r_done_cnt, r_done_cyc); end
        checks++; if (r_busy_cnt != 52) begin errors++; $display("FAIL ign_busy_cycles got=%0d exp=52", r_busy_cnt); end
    endtask

    task automatic test_back_to_back();
        run(3'd0, 13, 0, 0, 30);
        checks++; if (r_rd != 18 || r_wr != 18) begin errors++; $display("FAIL b2b_counts got=rd%0d/wr%0d exp=rd18/wr18", r_rd, r_wr); end
        checks++; if (r_done_cnt != 2 || r_done_last != 25) begin errors++; $display("FAIL b2b_done got=cnt%0d/last%0d exp=cnt2/last25", r_done_cnt, r_done_last); end
        checks++; if (r_busy_cnt != 24) begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=24", r_busy_cnt); end
        checks++; if (r_last_addr != 45 || r_last_cyc != 24) begin errors++; $display("FAIL b2b_last got=addr%0d/cyc%0d exp=addr45/cyc24", r_last_addr, r_last_cyc); end
    endtask

    task automatic test_illegal_size();
        run(3'd5, 0, 0, 0, 12);
        checks++; if (r_busy_cnt != 0) begin errors++; $display("FAIL ill_busy got=%0d exp=0", r_busy_cnt); end
        checks++; if (r_rd != 0 || r_wr != 0) begin errors++; $display("FAIL ill_activity got=rd%0d/wr%0d exp=rd0/wr0", r_rd, r_wr); end
        checks++; if (r_done_cnt != 0) begin errors++; $display("FAIL ill_done got=%0d exp=0", r_done_cnt); end
    endtask

    task automatic test_reset_abort();
        int late_wr, late_done, late_busy;
        late_wr = 0; late_done = 0; late_busy = 0;
        @(negedge clk);
        size_upsample = 3'd0;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 5) begin
                checks++; if (en_write_out !== 1'b1) begin errors++; $display("FAIL abort_pre_write got=%b exp=1", en_write_out); end
                rst = 1'b0;
            end
            if (c == 6) begin
                checks++; if ({busy, done, in_rd_en, en_write_out} !== 4'b0000) begin errors++; $display("FAIL abort_flags got=%b exp=0000", {busy, done, in_rd_en, en_write_out}); end
                checks++; if (in_addr !== 12'd0 || write_mode !== 4'd0 || addr_output !== 14'd0) begin errors++; $display("FAIL abort_buses got=%0d/%0d/%0d exp=0/0/0", in_addr, write_mode, addr_output); end
                rst = 1'b1;
            end
            if (c > 6) begin
                if (en_write_out) late_wr++;
                if (done) late_done++;
                if (busy) late_busy++;
            end
        end
        checks++; if (late_wr != 0 || late_done != 0 || late_busy != 0) begin errors++; $display("FAIL abort_after got=wr%0d/done%0d/busy%0d exp=0/0/0", late_wr, late_done, late_busy); end
        run(3'd0, 0, 0, 0, 16);
        checks++; if (r_wr != 9 || r_rd != 9) begin errors++; $display("FAIL rerun_counts got=wr%0d/rd%0d exp=9/9", r_wr, r_rd); end
        checks++; if (r_first_addr != 9 || r_first_cyc != 3 || r_first_mode != 0) begin errors++; $display("FAIL rerun_first got=addr%0d/cyc%0d/mode%0d exp=9/3/0", r_first_addr, r_first_cyc, r_first_mode); end
        checks++; if (r_last_addr != 45 || r_last_cyc != 11 || r_last_mode != 8) begin errors++; $display("FAIL rerun_last got=addr%0d/cyc%0d/mode%0d exp=45/11/8", r_last_addr, r_last_cyc, r_last_mode); end
        checks++; if (r_done_cyc != 12 || r_done_cnt != 1) begin errors++; $display("FAIL rerun_done got=cyc%0d/cnt%0d exp=12/1", r_done_cyc, r_done_cnt); end
        checks++; if (r_last_in_addr != 10) begin errors++; $display("FAIL rerun_in_addr got=%0d exp=10", r_last_in_addr); end
    endtask

    task automatic test_size4();
        run(3'd4, 0, 0, 0, 3980);
        checks++; if (r_wr != 3969) begin errors++; $display("FAIL s4_wr_count got=%0d exp=3969", r_wr); end
        checks++; if (r_last_addr != 16125 || r_last_mode != 8) begin errors++; $display("FAIL s4_last got=addr%0d/mode%0d exp=16125/8", r_last_addr, r_last_mode); end
        checks++; if (r_last_in_addr != 4030) begin errors++; $display("FAIL s4_last_in_addr got=%0d exp=4030", r_last_in_addr); end
        checks++; if (r_first_addr != 129 || r_first_mode != 0) begin errors++; $display("FAIL s4_first got=addr%0d/mode%0d exp=129/0", r_first_addr, r_first_mode); end
        checks++; if (r_done_cyc != 3972 || r_gap != 0) begin errors++; $display("FAIL s4_done got=cyc%0d/gaps%0d exp=3972/0", r_done_cyc, r_gap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_size1();
        test_start_ignored();
        test_back_to_back();
        test_illegal_size();
        test_reset_abort();
        test_size4();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
